// File: rtl/alu_mdu_pkg.sv
// Shared opcode table, FSM state type and decode helper for the ALU with iterative mul/div.
package alu_mdu_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_SLLV  = 6'h04;
  localparam logic [5:0] OP_SRLV  = 6'h06;
  localparam logic [5:0] OP_SRAV  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} md_state_e;

  // mult/multu/div/divu occupy 0x18..0x1B; bit 1 selects divide, bit 0 selects unsigned.
  function automatic logic is_md_op(logic [5:0] op);
    return op[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide engine: MD_STEP bits per cycle on operand magnitudes, with sign fixup
// applied combinationally to the final step so results are ready in the cycle done is high.
module alu_md_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MD_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int unsigned N  = WIDTH / MD_STEP;
  localparam int unsigned CW = $clog2(N);

  logic             busy_q, div_q, neg_q, neg_rem_q;
  logic [WIDTH-1:0] mb_q, acc_q, sh_q;
  logic [CW-1:0]    cnt_q;

  logic             a_neg, b_neg, qbit;
  logic [WIDTH-1:0] ma, mb, acc_n, sh_n, quo, rem;
  logic [WIDTH:0]   rtmp, sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    ma    = a_neg ? -a : a;
    mb    = b_neg ? -b : b;
  end

  // acc holds the running product high half / partial remainder; sh holds the multiplier
  // being consumed / the dividend being shifted out while quotient bits shift in.
  always_comb begin
    acc_n = acc_q;
    sh_n  = sh_q;
    rtmp  = '0;
    sum   = '0;
    qbit  = 1'b0;
    for (int i = 0; i < MD_STEP; i++) begin
      if (div_q) begin
        rtmp = {acc_n, sh_n[WIDTH-1]};
        qbit = rtmp >= {1'b0, mb_q};
        if (qbit) rtmp = rtmp - {1'b0, mb_q};
        acc_n = rtmp[WIDTH-1:0];
        sh_n  = {sh_n[WIDTH-2:0], qbit};
      end else begin
        sum   = {1'b0, acc_n} + (sh_n[0] ? {1'b0, mb_q} : '0);
        acc_n = sum[WIDTH:1];
        sh_n  = {sum[0], sh_n[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod     = {acc_n, sh_n};
    prod_fix = neg_q ? -prod : prod;
    quo      = neg_q ? -sh_n : sh_n;
    rem      = neg_rem_q ? -acc_n : acc_n;
    hi_res   = div_q ? rem : prod_fix[2*WIDTH-1:WIDTH];
    lo_res   = div_q ? quo : prod_fix[WIDTH-1:0];
    done     = busy_q & (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      mb_q      <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
    end else if (start) begin
      busy_q    <= 1'b1;
      div_q     <= is_div;
      // A zero divisor keeps the quotient all ones and the remainder equal to the dividend.
      neg_q     <= (a_neg ^ b_neg) & (~is_div | (b != '0));
      neg_rem_q <= is_div & a_neg;
      mb_q      <= mb;
      acc_q     <= '0;
      sh_q      <= ma;
      cnt_q     <= '0;
    end else if (busy_q) begin
      acc_q <= acc_n;
      sh_q  <= sh_n;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops, HI/LO moves, and an
// iterative multiply/divide path behind a valid/ready handshake.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MD_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned HW  = WIDTH / 2;

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_res, md_hi, md_lo;
  logic             accept, md_start, md_done;
  logic [SHW-1:0]   shamt;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid & in_ready;
  assign shamt    = op1[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: alu_res = op1 + op2;
      OP_SUB, OP_SUBU:                    alu_res = op1 - op2;
      OP_AND, OP_ANDI:                    alu_res = op1 & op2;
      OP_OR, OP_ORI:                      alu_res = op1 | op2;
      OP_XOR, OP_XORI:                    alu_res = op1 ^ op2;
      OP_NOR:                             alu_res = ~(op1 | op2);
      OP_SLT, OP_SLTI:                    alu_res[0] = $signed(op1) < $signed(op2);
      OP_SLTU, OP_SLTIU:                  alu_res[0] = op1 < op2;
      OP_SLL, OP_SLLV:                    alu_res = op2 << shamt;
      OP_SRL, OP_SRLV:                    alu_res = op2 >> shamt;
      OP_SRA, OP_SRAV:                    alu_res = $unsigned($signed(op2) >>> shamt);
      OP_LUI:                             alu_res = {op2[HW-1:0], op1[HW-1:0]};
      OP_MFHI:                            alu_res = hi_q;
      OP_MFLO:                            alu_res = lo_q;
      OP_MTHI, OP_MTLO:                   alu_res = op1;
      default:                            alu_res = '0;
    endcase
  end

  alu_md_iter #(
    .WIDTH  (WIDTH),
    .MD_STEP(MD_STEP)
  ) u_md_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .is_div   (opcode[1]),
    .is_signed(~opcode[0]),
    .a        (op1),
    .b        (op2),
    .done     (md_done),
    .hi_res   (md_hi),
    .lo_res   (md_lo)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    md_start    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_md_op(opcode)) begin
            md_start = 1'b1;
            state_d  = opcode[1] ? StDiv : StMul;
          end else begin
            out_d       = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
            if (opcode == OP_MTHI) hi_d = op1;
            if (opcode == OP_MTLO) lo_d = op1;
          end
        end
      end
      StMul, StDiv: begin
        // Results land on the last iteration edge so they are visible throughout FIN.
        if (md_done) begin
          hi_d        = md_hi;
          lo_d        = md_lo;
          out_d       = md_lo;
          zero_d      = (md_lo == '0);
          out_valid_d = 1'b1;
          state_d     = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_q       <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench: directed cases on the 32-bit/step-1 unit, randomized traffic with gaps
// on a 16-bit/step-2 unit, both checked against an arithmetic reference model.
module tb_alu_mdu;

  localparam logic [5:0] OP_SLL = 6'h00, OP_SRL = 6'h02, OP_SRA = 6'h03, OP_SLLV = 6'h04;
  localparam logic [5:0] OP_SRLV = 6'h06, OP_SRAV = 6'h07, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_MFHI = 6'h10, OP_MTHI = 6'h11;
  localparam logic [5:0] OP_MFLO = 6'h12, OP_MTLO = 6'h13, OP_MULT = 6'h18, OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV = 6'h1A, OP_DIVU = 6'h1B, OP_ADD = 6'h20, OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB = 6'h22, OP_SUBU = 6'h23, OP_AND = 6'h24, OP_OR = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26, OP_NOR = 6'h27, OP_SLT = 6'h2A, OP_SLTU = 6'h2B;

  localparam logic [5:0] OPS [34] = '{
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
    OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU,
    OP_DIV, OP_DIVU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, 6'h01, 6'h3F};
  localparam logic [15:0] CORNERS [5] = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv32, rdy32, ov32, z32;
  logic [5:0]  opc32;
  logic [31:0] a32, b32, out32, hi32, lo32;
  logic        iv16, rdy16, ov16, z16;
  logic [5:0]  opc16;
  logic [15:0] a16, b16, out16, hi16, lo16;

  int nvec = 0;
  int nerr = 0;

  alu_mdu u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .opcode(opc32), .op1(a32),
    .op2(b32), .out_valid(ov32), .out(out32), .zero(z32), .hi(hi32), .lo(lo32)
  );

  alu_mdu #(.WIDTH(16), .MD_STEP(2)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .opcode(opc16), .op1(a16),
    .op2(b16), .out_valid(ov16), .out(out16), .zero(z16), .hi(hi16), .lo(lo16)
  );

  function automatic longint sx(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 64'd1) != 0) return $signed(x) - (longint'(1) << w);
    return $signed(x);
  endfunction

  function automatic bit is_md(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Architectural model: result plus HI/LO after the op, from plain integer arithmetic.
  function automatic void model(input int w, input logic [5:0] op,
                                input longint unsigned a, input longint unsigned b,
                                input longint unsigned hi, input longint unsigned lo,
                                output longint unsigned r, output longint unsigned nhi,
                                output longint unsigned nlo);
    longint unsigned mask, hm;
    longint sa, sb, p;
    int sh;
    mask = (64'd1 << w) - 1;
    hm   = (64'd1 << (w / 2)) - 1;
    sa   = sx(a, w);
    sb   = sx(b, w);
    sh   = int'(a[4:0]) % w;
    nhi  = hi;
    nlo  = lo;
    r    = 0;
    case (op)
      OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: r = a + b;
      OP_SUB, OP_SUBU:                    r = a - b;
      OP_AND, OP_ANDI:                    r = a & b;
      OP_OR, OP_ORI:                      r = a | b;
      OP_XOR, OP_XORI:                    r = a ^ b;
      OP_NOR:                             r = ~(a | b);
      OP_SLT, OP_SLTI:                    r = (sa < sb) ? 1 : 0;
      OP_SLTU, OP_SLTIU:                  r = (a < b) ? 1 : 0;
      OP_SLL, OP_SLLV:                    r = b << sh;
      OP_SRL, OP_SRLV:                    r = b >> sh;
      OP_SRA, OP_SRAV:                    r = $unsigned(sb >>> sh);
      OP_LUI:                             r = ((b & hm) << (w / 2)) | (a & hm);
      OP_MFHI:                            r = hi;
      OP_MFLO:                            r = lo;
      OP_MTHI: begin r = a; nhi = a; end
      OP_MTLO: begin r = a; nlo = a; end
      OP_MULT: begin
        p = sa * sb;
        nhi = $unsigned(p >>> w) & mask;
        nlo = $unsigned(p) & mask;
        r = nlo;
      end
      OP_MULTU: begin
        nhi = ((a * b) >> w) & mask;
        nlo = (a * b) & mask;
        r = nlo;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          nlo = mask;
          nhi = a;
        end else if (op == OP_DIV) begin
          nlo = $unsigned(sa / sb) & mask;
          nhi = $unsigned(sa % sb) & mask;
        end else begin
          nlo = a / b;
          nhi = a % b;
        end
        r = nlo;
      end
      default: r = 0;
    endcase
    r = r & mask;
  endfunction

  // Issue one op on the 32-bit unit and wait for its result; lat = -1 on timeout.
  task automatic run32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard;
    guard = 0;
    while (!rdy32 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    opc32 = op; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; opc32 = 6'($urandom); a32 = $urandom; b32 = $urandom;
    lat = 1;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov32) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; iv32 = 1'b0; iv16 = 1'b0;
    opc32 = OP_ADDU; a32 = 32'h5; b32 = 32'h6; opc16 = OP_ADDU; a16 = 16'h1; b16 = 16'h2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    nvec++;
    if ({rdy32, ov32, z32, out32, hi32, lo32} !== {1'b1, 1'b0, 1'b0, 96'h0}) begin
      nerr++;
      $display("FAIL reset32 got rdy=%b ov=%b z=%b out=%h hi=%h lo=%h want 1 0 0 0 0 0",
               rdy32, ov32, z32, out32, hi32, lo32);
    end
    nvec++;
    if ({rdy16, ov16, z16, out16, hi16, lo16} !== {1'b1, 1'b0, 1'b0, 48'h0}) begin
      nerr++;
      $display("FAIL reset16 got rdy=%b ov=%b z=%b out=%h hi=%h lo=%h want 1 0 0 0 0 0",
               rdy16, ov16, z16, out16, hi16, lo16);
    end
  endtask

  task automatic test_back_to_back();
    opc32 = OP_ADDU; a32 = 32'h7FFF_FFFF; b32 = 32'h1; iv32 = 1'b1;
    @(posedge clk); #1;
    nvec++;
    if ({ov32, out32, z32} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      nerr++;
      $display("FAIL addu got ov=%b out=%h z=%b want 1 80000000 0", ov32, out32, z32);
    end
    opc32 = OP_SUBU; a32 = 32'h5; b32 = 32'h5;
    @(posedge clk); #1;
    nvec++;
    if ({ov32, out32, z32} !== {1'b1, 32'h0, 1'b1}) begin
      nerr++;
      $display("FAIL subu_b2b got ov=%b out=%h z=%b want 1 0 1", ov32, out32, z32);
    end
    iv32 = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if ({ov32, out32, z32} !== {1'b0, 32'h0, 1'b1}) begin
      nerr++;
      $display("FAIL hold got ov=%b out=%h z=%b want 0 0 1", ov32, out32, z32);
    end
  endtask

  task automatic test_shift();
    int lat;
    run32(OP_SRA, 32'h21, 32'h8000_0000, lat);
    nvec++;
    if ({out32, lat} !== {32'hC000_0000, 32'd1}) begin
      nerr++;
      $display("FAIL sra got out=%h lat=%0d want c0000000 1", out32, lat);
    end
    run32(OP_SRL, 32'h21, 32'h8000_0000, lat);
    nvec++;
    if ({out32, lat} !== {32'h4000_0000, 32'd1}) begin
      nerr++;
      $display("FAIL srl got out=%h lat=%0d want 40000000 1", out32, lat);
    end
  endtask

  task automatic test_mult();
    int low, ovc, ovat, lat;
    logic [31:0] rhi, rlo, rout;
    low = 0; ovc = 0; ovat = 0; rhi = '0; rlo = '0; rout = '0;
    opc32 = OP_MULT; a32 = 32'hFFFF_FFFD; b32 = 32'd7; iv32 = 1'b1;
    @(posedge clk); #1;
    // Keep a stray request asserted while busy; it must be ignored.
    opc32 = OP_ADDU; a32 = $urandom; b32 = $urandom;
    for (int c = 1; c <= 45; c++) begin
      if (c == 11) iv32 = 1'b0;
      if (rdy32) break;
      low++;
      if (ov32) begin
        ovc++;
        if (ovat == 0) begin ovat = c; rhi = hi32; rlo = lo32; rout = out32; end
      end
      @(posedge clk); #1;
    end
    nvec++;
    if ({ovat, low, ovc} !== {32'd33, 32'd33, 32'd1}) begin
      nerr++;
      $display("FAIL mult_timing got ov_at=%0d ready_low=%0d ov_count=%0d want 33 33 1",
               ovat, low, ovc);
    end
    nvec++;
    if ({rhi, rlo, rout} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB}) begin
      nerr++;
      $display("FAIL mult got hi=%h lo=%h out=%h want ffffffff ffffffeb ffffffeb",
               rhi, rlo, rout);
    end
    run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    nvec++;
    if ({hi32, lo32, lat} !== {32'hFFFF_FFFE, 32'h1, 32'd33}) begin
      nerr++;
      $display("FAIL multu got hi=%h lo=%h lat=%0d want fffffffe 00000001 33", hi32, lo32, lat);
    end
  endtask

  task automatic test_div();
    int lat;
    run32(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    nvec++;
    if ({lo32, hi32, out32, lat} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd33}) begin
      nerr++;
      $display("FAIL div got lo=%h hi=%h out=%h lat=%0d want fffffffd ffffffff fffffffd 33",
               lo32, hi32, out32, lat);
    end
    run32(OP_DIVU, 32'd7, 32'd0, lat);
    nvec++;
    if ({lo32, hi32, lat} !== {32'hFFFF_FFFF, 32'd7, 32'd33}) begin
      nerr++;
      $display("FAIL divu_by0 got lo=%h hi=%h lat=%0d want ffffffff 7 33", lo32, hi32, lat);
    end
    run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    nvec++;
    if ({lo32, hi32, z32} !== {32'h8000_0000, 32'h0, 1'b0}) begin
      nerr++;
      $display("FAIL div_ovf got lo=%h hi=%h z=%b want 80000000 0 0", lo32, hi32, z32);
    end
  endtask

  task automatic test_abort();
    int lat, ovc;
    run32(OP_MTHI, 32'hABCD, 32'h0, lat);
    opc32 = OP_DIV; a32 = 32'd100; b32 = 32'd3; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    ovc = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov32) ovc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if ({ov32, hi32, lo32, rdy32} !== {1'b0, 64'h0, 1'b1}) begin
      nerr++;
      $display("FAIL abort got ov=%b hi=%h lo=%h rdy=%b want 0 0 0 1", ov32, hi32, lo32, rdy32);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) ovc++;
    end
    nvec++;
    if (ovc !== 0) begin
      nerr++;
      $display("FAIL abort_no_ov got %0d out_valid pulses want 0", ovc);
    end
    run32(OP_MTHI, 32'h1234, 32'h0, lat);
    run32(OP_MFHI, 32'h0, 32'h0, lat);
    nvec++;
    if ({out32, hi32, lat} !== {32'h1234, 32'h1234, 32'd1}) begin
      nerr++;
      $display("FAIL mfhi got out=%h hi=%h lat=%0d want 1234 1234 1", out32, hi32, lat);
    end
  endtask

  typedef struct {
    longint unsigned r;
    longint unsigned h;
    longint unsigned l;
    int              lat;
    int              t;
  } exp_t;

  task automatic test_random16();
    exp_t q[$];
    exp_t e;
    longint unsigned mhi, mlo, r, nh, nl;
    int cyc;
    mhi = 0; mlo = 0; cyc = 0;
    for (int n = 0; n < 3020; n++) begin
      if (n < 3000) begin
        iv16  = ($urandom_range(0, 3) != 0);
        opc16 = OPS[$urandom_range(0, 33)];
        a16   = ($urandom_range(0, 3) == 0) ? CORNERS[$urandom_range(0, 4)] : 16'($urandom);
        b16   = ($urandom_range(0, 3) == 0) ? CORNERS[$urandom_range(0, 4)] : 16'($urandom);
      end else begin
        iv16 = 1'b0;
      end
      if (iv16 && rdy16) begin
        model(16, opc16, 64'(a16), 64'(b16), mhi, mlo, r, nh, nl);
        e.r = r; e.h = nh; e.l = nl; e.lat = is_md(opc16) ? 9 : 1; e.t = cyc;
        q.push_back(e);
        mhi = nh; mlo = nl;
      end
      @(posedge clk); #1;
      cyc++;
      if (ov16) begin
        nvec++;
        if (q.size() == 0) begin
          nerr++;
          $display("FAIL rand16_spurious out_valid at cycle %0d with nothing pending", cyc);
        end else begin
          e = q.pop_front();
          if ({out16, z16, hi16, lo16, cyc - e.t} !==
              {e.r[15:0], e.r == 0, e.h[15:0], e.l[15:0], e.lat}) begin
            nerr++;
            $display("FAIL rand16 got out=%h z=%b hi=%h lo=%h lat=%0d want %h %b %h %h %0d",
                     out16, z16, hi16, lo16, cyc - e.t, e.r[15:0], e.r == 0, e.h[15:0],
                     e.l[15:0], e.lat);
          end
        end
      end
    end
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL rand16_lost got %0d results outstanding want 0", q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_shift();
    test_mult();
    test_div();
    test_abort();
    test_random16();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
